// File: rtl/mc_pkg.sv
// mc_pkg: shared FP32 constants, action encoding and ordering key for the MountainCar core.
package mc_pkg;
    localparam logic [31:0] VEL_MAX   = 32'h3D8F5C29;
    localparam logic [31:0] VEL_MIN   = 32'hBD8F5C29;
    localparam logic [31:0] POS_MAX   = 32'h3F19999A;
    localparam logic [31:0] POS_MIN   = 32'hBF99999A;
    localparam logic [31:0] GOAL_POS  = 32'h3F000000;
    localparam logic [31:0] RESET_POS = 32'hBF000000;

    typedef enum logic [1:0] {ACT_LEFT = 2'd0, ACT_NONE = 2'd1, ACT_RIGHT = 2'd2} action_t;

    // Monotonic unsigned key for FP32 ordering; -0 is folded onto +0.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        return (x == 32'h80000000) ? 32'h80000000 : x[31] ? ~x : (x | 32'h80000000);
    endfunction
endpackage

// File: rtl/mc_fp32_clamp.sv
// mc_fp32_clamp: combinational FP32 clamp of value into [lo, hi] with bound-hit flags.
module mc_fp32_clamp
    import mc_pkg::*;
(
    input  logic [31:0] value,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [31:0] clamped,
    output logic        hit_lo,
    output logic        hit_hi
);
    always_comb begin
        hit_lo  = fp32_key(value) < fp32_key(lo);
        hit_hi  = fp32_key(value) > fp32_key(hi);
        clamped = hit_lo ? lo : hit_hi ? hi : value;
    end
endmodule

// File: rtl/mountaincar_step_ctrl.sv
// mountaincar_step_ctrl: MountainCar environment-step sequencer driving the velocity unit
// and an external FP32 adder, then applying velocity/position bounds, wall and goal rules.
module mountaincar_step_ctrl
    import mc_pkg::*;
#(
    parameter int VEL_WL  = 32,
    parameter int POS_WL  = 32,
    parameter int ACT_WL  = 2,
    parameter int TIMEOUT = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_valid,
    input  logic [POS_WL-1:0] i_init_pos,
    input  logic              i_act_valid,
    output logic              o_act_ready,
    input  logic [ACT_WL-1:0] i_act,
    output logic              o_cv_ena,
    output logic [VEL_WL-1:0] o_cv_vel,
    output logic [POS_WL-1:0] o_cv_pos,
    output logic [ACT_WL-1:0] o_cv_act,
    input  logic              i_cv_valid,
    input  logic [VEL_WL-1:0] i_cv_vel,
    output logic              o_add_ena,
    output logic [POS_WL-1:0] o_add_a,
    output logic [VEL_WL-1:0] o_add_b,
    input  logic              i_add_valid,
    input  logic [POS_WL-1:0] i_add_sum,
    output logic              o_step_valid,
    output logic [POS_WL-1:0] o_pos,
    output logic [VEL_WL-1:0] o_vel,
    output logic              o_done,
    output logic              o_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CV_WAIT, VEL_CLIP, ADD_WAIT, POS_CLIP, OUT} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [VEL_WL-1:0] vel_raw, vel_clip;
    logic [POS_WL-1:0] sum_raw, pos_clip;
    logic              vel_lo, vel_hi, pos_lo, pos_hi;
    logic              vel_neg, at_wall, goal;

    mc_fp32_clamp u_vel_clamp (
        .value(vel_raw), .lo(VEL_MIN), .hi(VEL_MAX),
        .clamped(vel_clip), .hit_lo(vel_lo), .hit_hi(vel_hi)
    );

    mc_fp32_clamp u_pos_clamp (
        .value(sum_raw), .lo(POS_MIN), .hi(POS_MAX),
        .clamped(pos_clip), .hit_lo(pos_lo), .hit_hi(pos_hi)
    );

    // A negative zero velocity is not "moving left", so it survives the wall rule.
    always_comb begin
        vel_neg = vel_lo || (!vel_hi && vel_clip[VEL_WL-1] && |vel_clip[VEL_WL-2:0]);
        at_wall = pos_lo || pos_clip == POS_MIN;
        goal    = pos_hi || fp32_key(pos_clip) >= fp32_key(GOAL_POS);
    end

    assign o_act_ready = i_rst_n && !i_init_valid && state == IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            vel_raw      <= '0;
            sum_raw      <= '0;
            o_cv_ena     <= 1'b0;
            o_cv_vel     <= '0;
            o_cv_pos     <= '0;
            o_cv_act     <= '0;
            o_add_ena    <= 1'b0;
            o_add_a      <= '0;
            o_add_b      <= '0;
            o_step_valid <= 1'b0;
            o_pos        <= RESET_POS;
            o_vel        <= '0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else if (i_init_valid) begin
            state        <= IDLE;
            o_cv_ena     <= 1'b0;
            o_add_ena    <= 1'b0;
            o_step_valid <= 1'b0;
            o_pos        <= i_init_pos;
            o_vel        <= '0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_step_valid <= 1'b0;
            case (state)
                IDLE: if (i_act_valid) begin
                    state    <= CV_WAIT;
                    cnt      <= '0;
                    o_cv_ena <= 1'b1;
                    o_cv_vel <= o_vel;
                    o_cv_pos <= o_pos;
                    o_cv_act <= (i_act > ACT_WL'(ACT_RIGHT)) ? ACT_WL'(ACT_NONE) : i_act;
                end
                CV_WAIT: if (i_cv_valid) begin
                    vel_raw  <= i_cv_vel;
                    o_cv_ena <= 1'b0;
                    state    <= VEL_CLIP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    o_err    <= 1'b1;
                    o_cv_ena <= 1'b0;
                    state    <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                VEL_CLIP: begin
                    o_add_ena <= 1'b1;
                    o_add_a   <= o_pos;
                    o_add_b   <= vel_clip;
                    cnt       <= '0;
                    state     <= ADD_WAIT;
                end
                ADD_WAIT: if (i_add_valid) begin
                    sum_raw   <= i_add_sum;
                    o_add_ena <= 1'b0;
                    state     <= POS_CLIP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    o_err     <= 1'b1;
                    o_add_ena <= 1'b0;
                    state     <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                POS_CLIP: begin
                    o_pos        <= pos_clip;
                    o_vel        <= (at_wall && vel_neg) ? '0 : o_add_b;
                    o_done       <= goal;
                    o_step_valid <= 1'b1;
                    state        <= OUT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
